scdec_win: RTL and testbench
============================

Name: scdec_win

Overview:
- Downstream stage of the correlated stochastic divider.
- Converts a unipolar stochastic bitstream (e.g. the divider quotient) into a binary count over a fixed window of 2^LEN_LOG2 valid bits.
- Discards a configurable warm-up prefix so that the divider's start-up transient is excluded from the result.
- Delivers the result on a valid/ready handshake, in single-shot or continuous mode.

Parameters:
- LEN_LOG2, 8, log2 of the accumulation window length in valid bits (window N = 2^LEN_LOG2); legal range 1..16.
- SKIP, 16, number of valid bits discarded after start before accumulation begins; 0 means no warm-up.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; begins a conversion; honoured only in IDLE
- abort  in  1  synchronous clear to IDLE; has priority over all other inputs
- cont  in  1  continuous mode; sampled at each result handshake
- bit_in  in  1  stochastic bit
- bit_vld  in  1  bit_in is valid this cycle
- result  out  LEN_LOG2+1  count of ones in the window (0..N inclusive)
- result_vld  out  1  result is valid
- result_rdy  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; a valid bit arrived while in DONE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; skip_cnt, len_cnt and ones_cnt cleared.
  - result=0, result_vld=0, busy=0, overrun=0.
- States are IDLE, WARM, ACC, DONE.
- IDLE:
  - start=1 moves to WARM if SKIP>0, otherwise to ACC. All counters clear and overrun clears.
  - bit_vld is ignored.
- WARM:
  - Each bit_vld increments skip_cnt.
  - On the cycle carrying the SKIP-th valid bit, move to ACC. That bit is not accumulated.
- ACC:
  - Each bit_vld increments len_cnt and adds bit_in to ones_cnt.
  - On the valid bit with len_cnt==N-1, register result=ones_cnt+bit_in and set result_vld=1 in the next cycle. Move to DONE.
  - Latency: result_vld rises exactly one clock after the N-th accumulated valid bit.
- DONE:
  - result and result_vld hold stable until the handshake (result_vld & result_rdy).
  - Any bit_vld in DONE is dropped and sets overrun. overrun holds until the next start or reset.
  - On handshake, result_vld clears next cycle. If cont=1, move to ACC (no warm-up repeat, counters cleared); otherwise move to IDLE.
  - result keeps its last value after the handshake until overwritten.
- abort:
  - From any state, go to IDLE next cycle and clear counters and result_vld.
  - result is not cleared; overrun is kept.
- start outside IDLE is ignored. start and abort in the same cycle: abort wins.
- Width rules:
  - ones_cnt and result are LEN_LOG2+1 bits, so an all-ones window gives exactly N with no wrap.
  - len_cnt is LEN_LOG2 bits; skip_cnt is clog2(SKIP+1) bits.
- Gaps in bit_vld stall all counters; no timeout.
- Reset mid-operation behaves as above (async); no partial result is ever flagged valid.

Decomposition:
- Shared package scu_pkg holds:
  - the state enum type (IDLE, WARM, ACC, DONE) as scdec_state_t;
  - a helper constant function for counter widths.
- One natural sub-module: sc_ones_cnt, the LEN_LOG2-parameterised window counter. It provides clear, enable and bit_in inputs, plus ones_cnt and a last-bit flag. It is reusable by other stochastic-to-binary blocks.
- The FSM and handshake stay in scdec_win.

Test Plan (all scenarios use LEN_LOG2=4, N=16, SKIP=2):
- Reset: hold rst_n low with random inputs -> result=0, result_vld=0, busy=0, overrun=0.
- All ones: start, then 18 valid bits of bit_in=1 -> result_vld=1 one cycle after the 18th bit, result=16; result_rdy=1 -> IDLE, busy=0.
- Alternating 1,0 after the 2 skipped bits, with bit_vld gapped every third cycle -> result=8, and the stall leaves the count unchanged.
- Backpressure: hold result_rdy=0 for 5 cycles while feeding 3 valid bits -> result stays stable, result_vld stays 1, overrun=1 remains set until the next start.
- Continuous mode: cont=1, window 1 all zeros (result=0), window 2 all ones -> second result=16. Window 2 counts starting the cycle after the handshake, with no skip.
- Abort: assert abort after 7 accumulated bits -> IDLE next cycle, result_vld never rises, busy=0. Repeat with rst_n pulsed mid-ACC -> same outcome, asynchronously.

Source files
------------

// File: rtl/scu_pkg.sv
// Shared types and helpers for the stochastic-to-binary conversion blocks.
package scu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } scdec_state_t;

  // Bits needed to hold every value 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sc_ones_cnt.sv
// Window counter: counts valid bits and ones over a 2^LEN_LOG2-bit window.
module sc_ones_cnt
  import scu_pkg::*;
#(
  parameter int LEN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                bit_in,
  output logic [LEN_LOG2:0]   ones_cnt,
  output logic                last
);

  localparam int ONES_W = cnt_width(2 ** LEN_LOG2);

  logic [LEN_LOG2-1:0] r_len_cnt;
  logic [ONES_W-1:0]   r_ones_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (clr) begin
      r_len_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (en) begin
      r_len_cnt  <= r_len_cnt + LEN_LOG2'(1);
      r_ones_cnt <= r_ones_cnt + ONES_W'(bit_in);
    end
  end

  assign ones_cnt = r_ones_cnt;
  // The window length is a power of two, so the final bit is len_cnt all-ones.
  assign last     = &r_len_cnt;

endmodule

// File: rtl/scdec_win.sv
// Stochastic bitstream to binary count over a fixed window, with warm-up
// discard and a valid/ready result port (single-shot or continuous).
module scdec_win
  import scu_pkg::*;
#(
  parameter int LEN_LOG2 = 8,
  parameter int SKIP     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic                bit_in,
  input  logic                bit_vld,
  output logic [LEN_LOG2:0]   result,
  output logic                result_vld,
  input  logic                result_rdy,
  output logic                busy,
  output logic                overrun
);

  localparam int SKIP_W = cnt_width(SKIP);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  scdec_state_t        r_state, w_state_next;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [LEN_LOG2:0]   r_result;
  logic                r_result_vld;
  logic                r_overrun;

  logic [LEN_LOG2:0]   w_ones_cnt;
  logic                w_last;
  logic                w_hs;
  logic                w_acc_en;
  logic                w_win_end;
  logic                w_cnt_clr;

  assign w_hs      = r_result_vld & result_rdy;
  assign w_acc_en  = (r_state == ACC) & bit_vld & ~abort;
  assign w_win_end = w_acc_en & w_last;
  // Window counter only runs in ACC; holding it clear elsewhere covers
  // start, abort and the continuous-mode restart in one place.
  assign w_cnt_clr = abort | (r_state != ACC);

  sc_ones_cnt #(.LEN_LOG2(LEN_LOG2)) u_ones_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_cnt_clr),
    .en       (w_acc_en),
    .bit_in   (bit_in),
    .ones_cnt (w_ones_cnt),
    .last     (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) w_state_next = (SKIP > 0) ? WARM : ACC;
        WARM: if (bit_vld && (r_skip_cnt == SKIP_LAST)) w_state_next = ACC;
        ACC:  if (bit_vld && w_last) w_state_next = DONE;
        DONE: if (w_hs) w_state_next = cont ? ACC : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
    end else if (abort || (r_state != WARM)) begin
      r_skip_cnt <= '0;
    end else if (bit_vld) begin
      r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result     <= '0;
      r_result_vld <= 1'b0;
    end else if (abort) begin
      r_result_vld <= 1'b0;
    end else if (w_win_end) begin
      r_result     <= w_ones_cnt + (LEN_LOG2 + 1)'(bit_in);
      r_result_vld <= 1'b1;
    end else if (w_hs) begin
      r_result_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (!abort) begin
      if ((r_state == IDLE) && start) begin
        r_overrun <= 1'b0;
      end else if ((r_state == DONE) && bit_vld) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign result     = r_result;
  assign result_vld = r_result_vld;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_scdec_win.sv
// Directed + randomized bench for scdec_win (LEN_LOG2=4, SKIP=2).
module tb_scdec_win;

  localparam int LEN_LOG2 = 4;
  localparam int N        = 16;
  localparam int SKIP     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cont = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_vld = 1'b0;
  logic              result_rdy = 1'b0;
  logic [LEN_LOG2:0] result;
  logic              result_vld;
  logic              busy;
  logic              overrun;

  int tests = 0;
  int fails = 0;
  int vq[$];
  logic [31:0] exp_res;
  logic [31:0] last_res;

  scdec_win #(.LEN_LOG2(LEN_LOG2), .SKIP(SKIP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cont       (cont),
    .bit_in     (bit_in),
    .bit_vld    (bit_vld),
    .result     (result),
    .result_vld (result_vld),
    .result_rdy (result_rdy),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, step past the edge, drop one-shot inputs.
  task automatic cyc(input logic v, input logic b);
    bit_vld = v;
    bit_in  = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    abort   = 1'b0;
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1'b1, 1'b1);
    chk("start_busy", 32'(busy), 1);
    chk("start_ovr_clr", 32'(overrun), 0);
  endtask

  // Feeds nskip discarded bits (all ones) then N window bits; expected
  // value is the number of ones among valid bits nskip..nskip+N-1.
  // pat: 0 zeros, 1 ones, 2 alternating 1/0, 3 random with random gaps.
  task automatic window(input string tag, input int nskip, input int pat, input bit gap);
    int k;
    int c;
    logic v;
    logic b;
    vq.delete();
    k = 0;
    c = 0;
    while (k < nskip + N && c < 2000) begin
      v = !(gap && (c % 3 == 2));
      if (pat == 3 && $urandom_range(0, 3) == 0) v = 1'b0;
      if (k < nskip)      b = 1'b1;
      else if (pat == 0)  b = 1'b0;
      else if (pat == 1)  b = 1'b1;
      else if (pat == 2)  b = ((k - nskip) % 2 == 0);
      else                b = 1'($urandom_range(0, 1));
      if (pat == 3 && k == nskip + 4) start = 1'b1;
      cyc(v, b);
      if (v) begin
        vq.push_back(int'(b));
        k++;
      end
      c++;
      if (k < nskip + N) chk({tag, "_vld_early"}, 32'(result_vld), 0);
    end
    exp_res = 0;
    for (int i = nskip; i < nskip + N && i < vq.size(); i++) exp_res += 32'(vq[i]);
    chk({tag, "_vld"}, 32'(result_vld), 1);
    chk({tag, "_result"}, 32'(result), exp_res);
    chk({tag, "_busy"}, 32'(busy), 1);
    last_res = exp_res;
  endtask

  task automatic handshake(input string tag, input logic c);
    result_rdy = 1'b1;
    cont = c;
    cyc(1'b0, 1'b0);
    result_rdy = 1'b0;
    cont = 1'b0;
    chk({tag, "_vld_clr"}, 32'(result_vld), 0);
    chk({tag, "_busy"}, 32'(busy), 32'(c));
    chk({tag, "_res_hold"}, 32'(result), last_res);
  endtask

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); abort = 1'($urandom); cont = 1'($urandom);
      bit_in = 1'($urandom); bit_vld = 1'($urandom); result_rdy = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_result", 32'(result), 0);
    chk("rst_vld", 32'(result_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    start = 0; abort = 0; cont = 0; bit_in = 0; bit_vld = 0; result_rdy = 0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);
    chk("idle_ignores_bits", 32'(busy), 0);

    // All ones: 2 skipped + 16 ones -> 16.
    do_start();
    window("ones", SKIP, 1, 1'b0);
    handshake("ones_hs", 1'b0);

    // Alternating with gaps -> 8; then random windows with gaps and a stray start.
    do_start();
    window("alt", SKIP, 2, 1'b1);
    handshake("alt_hs", 1'b0);
    for (int r = 0; r < 4; r++) begin
      do_start();
      window("rnd", SKIP, 3, 1'b1);
      handshake("rnd_hs", 1'b0);
    end

    // Backpressure with 3 dropped bits in DONE.
    do_start();
    window("bp", SKIP, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3, 1'b1);
      chk("bp_result", 32'(result), last_res);
      chk("bp_vld", 32'(result_vld), 1);
      chk("bp_ovr", 32'(overrun), 1);
    end
    handshake("bp_hs", 1'b0);
    chk("bp_ovr_idle", 32'(overrun), 1);
    do_start();

    // Continuous: zeros window (skipped ones excluded), then ones with no skip.
    window("cont1", SKIP, 0, 1'b0);
    chk("cont1_zero", 32'(result), 0);
    handshake("cont1_hs", 1'b1);
    window("cont2", 0, 1, 1'b0);
    chk("cont2_full", 32'(result), 16);
    handshake("cont2_hs", 1'b1);
    window("cont3", 0, 3, 1'b1);
    handshake("cont3_hs", 1'b0);

    // Abort after 7 accumulated bits (start in same cycle loses).
    do_start();
    for (int i = 0; i < SKIP + 7; i++) cyc(1'b1, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    cyc(1'b1, 1'b1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vld", 32'(result_vld), 0);
    chk("abort_res_kept", 32'(result), last_res);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      chk("abort_no_vld", 32'(result_vld), 0);
    end
    chk("abort_idle", 32'(busy), 0);

    // Asynchronous reset mid-ACC.
    do_start();
    for (int i = 0; i < SKIP + 5; i++) cyc(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_vld", 32'(result_vld), 0);
    chk("arst_result", 32'(result), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      chk("arst_no_vld", 32'(result_vld), 0);
    end
    chk("arst_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
